pdm_speaker_tx: RTL

- Audio output counterpart to the PDM microphone capture path.
- Accepts signed PCM samples over a valid/ready stream and buffers them in a small FIFO.
- Consumes one sample per sample_tick and converts it to a 1-bit PDM stream with a first-order sigma-delta modulator, advanced on bit_tick.
- Drives the board mono audio amplifier: AUD_PWM is the data line and AUD_SD is the amplifier enable. Used for the timer alarm tone and for mic loopback.

---
 rtl/audio_pkg.sv | 21 ++
 rtl/sync_fifo.sv | 56 +++++
 rtl/pdm_speaker_tx.sv | 130 +++++++++++++
 3 files changed

// File: rtl/audio_pkg.sv
// Shared audio-path definitions: sample width, offset-binary midscale, speaker FSM encoding.
package audio_pkg;

  localparam int SAMPLE_W_DEFAULT = 16;

  localparam logic [SAMPLE_W_DEFAULT-1:0] MIDSCALE = SAMPLE_W_DEFAULT'(1) << (SAMPLE_W_DEFAULT - 1);

  typedef enum logic [1:0] {
    ST_OFF     = 2'd0,
    ST_STARTUP = 2'd1,
    ST_RUN     = 2'd2
  } spk_state_t;

  // Two's complement to offset binary: most negative maps to 0, most positive to all ones.
  function automatic logic [SAMPLE_W_DEFAULT-1:0] pcm_to_offset(
    input logic [SAMPLE_W_DEFAULT-1:0] s
  );
    return {~s[SAMPLE_W_DEFAULT-1], s[SAMPLE_W_DEFAULT-2:0]};
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with flush; head word is read straight from the storage registers.
// A word pushed in one cycle becomes visible at the head from the next cycle on.
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic                     i_flush,
  input  logic [WIDTH-1:0]         i_din,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic [WIDTH-1:0]         o_dout
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_level;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_level == (AW+1)'(DEPTH));
  assign o_empty = (r_level == '0);
  assign o_level = r_level;
  assign o_dout  = r_mem[r_rd_ptr];

  assign w_push = i_push && !o_full && !i_flush;
  assign w_pop  = i_pop && !o_empty && !i_flush;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_level <= r_level + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_din;
  end

endmodule

// File: rtl/pdm_speaker_tx.sv
// PCM stream to 1-bit PDM for the mono amplifier: FIFO buffer, first-order sigma-delta on bit_tick,
// amplifier startup delay before samples are played. Dropping enable_spk shuts down and flushes.
module pdm_speaker_tx
  import audio_pkg::*;
#(
  parameter int SAMPLE_W      = SAMPLE_W_DEFAULT,
  parameter int FIFO_DEPTH    = 4,
  parameter int STARTUP_TICKS = 64
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable_spk,
  input  logic                          bit_tick,
  input  logic                          sample_tick,
  input  logic [SAMPLE_W-1:0]           s_data,
  input  logic                          s_valid,
  output logic                          s_ready,
  output logic                          AUD_PWM,
  output logic                          AUD_SD,
  output logic                          underrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int CW = $clog2(STARTUP_TICKS + 1);

  spk_state_t          r_state;
  spk_state_t          w_state_nxt;
  logic [CW-1:0]       r_cnt;
  logic [SAMPLE_W-1:0] r_acc;
  logic [SAMPLE_W-1:0] r_cur;
  logic                r_pwm;
  logic                r_sd;
  logic                r_underrun;

  logic                w_full;
  logic                w_empty;
  logic [SAMPLE_W-1:0] w_head;
  logic                w_push;
  logic                w_pop;
  logic                w_flush;
  logic                w_startup_done;
  logic [SAMPLE_W:0]   w_sum;

  assign s_ready  = (r_state != ST_OFF) && !w_full;
  assign w_push   = s_valid && s_ready && enable_spk;
  assign w_pop    = enable_spk && (r_state == ST_RUN) && sample_tick && !w_empty;
  assign w_flush  = !enable_spk || (r_state == ST_OFF);

  assign w_startup_done = (r_state == ST_STARTUP) && bit_tick &&
                          (r_cnt == CW'(STARTUP_TICKS - 1));

  // The carry out of the accumulator is the PDM bit.
  assign w_sum = {1'b0, r_acc} + {1'b0, r_cur};

  sync_fifo #(
    .WIDTH (SAMPLE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (w_flush),
    .i_din   (s_data),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (fifo_level),
    .o_dout  (w_head)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_OFF;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (!enable_spk) begin
      w_state_nxt = ST_OFF;
    end else begin
      case (r_state)
        ST_OFF:     w_state_nxt = ST_STARTUP;
        ST_STARTUP: if (w_startup_done) w_state_nxt = ST_RUN;
        ST_RUN:     w_state_nxt = ST_RUN;
        default:    w_state_nxt = ST_OFF;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sd       <= 1'b0;
      r_pwm      <= 1'b0;
      r_underrun <= 1'b0;
      r_acc      <= '0;
      r_cur      <= SAMPLE_W'(MIDSCALE);
      r_cnt      <= '0;
    end else if (!enable_spk) begin
      // Underrun deliberately survives shutdown so software can read it afterwards.
      r_sd  <= 1'b0;
      r_pwm <= 1'b0;
      r_acc <= '0;
      r_cur <= SAMPLE_W'(MIDSCALE);
      r_cnt <= '0;
    end else if (r_state == ST_OFF) begin
      r_sd       <= 1'b1;
      r_cnt      <= '0;
      r_underrun <= 1'b0;
    end else begin
      if ((r_state == ST_STARTUP) && bit_tick) r_cnt <= r_cnt + 1'b1;
      if ((r_state == ST_RUN) && sample_tick) begin
        if (!w_empty) begin
          r_cur <= SAMPLE_W'(pcm_to_offset(SAMPLE_W_DEFAULT'(w_head)));
        end else begin
          r_cur      <= SAMPLE_W'(MIDSCALE);
          r_underrun <= 1'b1;
        end
      end
      if (bit_tick) begin
        r_acc <= w_sum[SAMPLE_W-1:0];
        r_pwm <= w_sum[SAMPLE_W];
      end
    end
  end

  assign AUD_PWM  = r_pwm;
  assign AUD_SD   = r_sd;
  assign underrun = r_underrun;

endmodule
